// File: rtl/disp_pkg.sv
// Shared definitions for the display scan controller.
// Holds the digit count, nibble width, the digit index type, the one-hot
// digit-select encoding and helpers that pick or test nibbles of the
// 16-bit shadow value. Digit 1 (leftmost) is index 0 and occupies the
// shadow bits [15:12].
package disp_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int NIBBLE_W   = 4;
  localparam int SHADOW_W   = NUM_DIGITS * NIBBLE_W;

  typedef logic [1:0]            digit_idx_t;
  typedef logic [NUM_DIGITS-1:0] dig_sel_t;
  typedef logic [NIBBLE_W-1:0]   nibble_t;
  typedef logic [SHADOW_W-1:0]   shadow_t;

  // One-hot select: index 0 (digit 1) drives the MSB of dig_sel.
  function automatic dig_sel_t onehot_sel(input digit_idx_t idx);
    dig_sel_t sel;
    case (idx)
      2'd0:    sel = 4'b1000;
      2'd1:    sel = 4'b0100;
      2'd2:    sel = 4'b0010;
      default: sel = 4'b0001;
    endcase
    return sel;
  endfunction

  function automatic nibble_t nibble_at(input shadow_t s, input digit_idx_t idx);
    nibble_t n;
    case (idx)
      2'd0:    n = s[15:12];
      2'd1:    n = s[11:8];
      2'd2:    n = s[7:4];
      default: n = s[3:0];
    endcase
    return n;
  endfunction

  // True when the digit at idx and every digit to its left are zero.
  // The rightmost digit is never reported as a leading zero.
  function automatic logic leading_zero(input shadow_t s, input digit_idx_t idx);
    logic lz;
    case (idx)
      2'd0:    lz = (s[15:12] == 4'h0);
      2'd1:    lz = (s[15:8]  == 8'h00);
      2'd2:    lz = (s[15:4]  == 12'h000);
      default: lz = 1'b0;
    endcase
    return lz;
  endfunction

endpackage

// File: rtl/disp_scan_ctrl_scan_tick.sv
// scan_tick: parameterised slot counter for the display scanner.
// Ports:
//   clk, rst      clock and asynchronous active-low reset
//   en_i          advance the counter; when low the counter is held
//   bright_i      brightness, captured only while the counter is 0
//   tc_o          counter is at terminal count (TICK_DIV-1)
//   on_nxt_o      the counter value about to be loaded lies inside the
//                 on-window, so the parent can register its digit select
//                 in step with the counter
import disp_pkg::*;

module scan_tick #(
  parameter int TICK_DIV = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [2:0] bright_i,
  output logic       tc_o,
  output logic       on_nxt_o
);

  localparam int CW    = $clog2(TICK_DIV);
  localparam int SLOT8 = TICK_DIV / 8;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bright_q, bright_d;

  assign tc_o = (cnt_q == CW'(TICK_DIV - 1));

  // The brightness used for a slot is captured in the slot's first cycle;
  // the window test for the next count therefore sees the live input on
  // that one edge and the held copy afterwards. Count 0 is always inside
  // the window, so the stale copy used at the slot boundary is harmless.
  always_comb begin
    cnt_d    = cnt_q;
    bright_d = bright_q;
    if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + CW'(1);
      if (cnt_q == '0) begin
        bright_d = bright_i;
      end
    end
  end

  assign on_nxt_o = (int'(cnt_d) < (int'(bright_d) + 1) * SLOT8);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      bright_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      bright_q <= bright_d;
    end
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: time-multiplexed 4-digit display scanner.
// Ports:
//   clk, rst   clock and asynchronous active-low reset
//   en         scan enable; when low the scan position is frozen and the
//              display is dark, and load requests are taken immediately
//   ld_req     load request, held until ld_ack
//   ld_data    four BCD nibbles, [15:12] is the leftmost digit
//   ld_ack     one-cycle acknowledge of a completed load
//   bright     brightness, on-fraction (bright+1)/8 of each slot
//   blank_lz   suppress leading zeros on digits 1..3
//   digit      nibble of the active digit
//   dig_sel    one-hot active-high digit enable, [3] is digit 1
//   frame      one-cycle pulse at each frame start
// Every output is a flop. Digit and select registers are loaded from the
// next-state index and shadow so they line up with the counter.
import disp_pkg::*;

module disp_scan_ctrl #(
  parameter int TICK_DIV = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        ld_req,
  input  logic [15:0] ld_data,
  output logic        ld_ack,
  input  logic [2:0]  bright,
  input  logic        blank_lz,
  output logic [3:0]  digit,
  output logic [3:0]  dig_sel,
  output logic        frame
);

  digit_idx_t idx_q, idx_d;
  shadow_t    shadow_q, shadow_d;
  nibble_t    digit_q, digit_d;
  dig_sel_t   dig_sel_q, dig_sel_d;
  logic       ld_ack_q, ld_ack_d;
  logic       frame_q, frame_d;

  logic tc, on_nxt;
  logic slot_end, boundary, load;

  scan_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_scan_tick (
    .clk      (clk),
    .rst      (rst),
    .en_i     (en),
    .bright_i (bright),
    .tc_o     (tc),
    .on_nxt_o (on_nxt)
  );

  // A load is taken at a frame boundary, or at once while scanning is
  // stopped. The cycle carrying ld_ack ignores ld_req so a requester that
  // is still holding it is not acknowledged twice for one transfer.
  always_comb begin
    slot_end = en && tc;
    boundary = slot_end && (idx_q == 2'd3);
    load     = ld_req && !ld_ack_q && (boundary || !en);

    idx_d    = slot_end ? idx_q + 2'd1 : idx_q;
    shadow_d = load ? ld_data : shadow_q;
    ld_ack_d = load;
    frame_d  = boundary;

    digit_d   = nibble_at(shadow_d, idx_d);
    dig_sel_d = '0;
    if (en && on_nxt && !(blank_lz && leading_zero(shadow_d, idx_d))) begin
      dig_sel_d = onehot_sel(idx_d);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q     <= '0;
      shadow_q  <= '0;
      digit_q   <= '0;
      dig_sel_q <= '0;
      ld_ack_q  <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      digit_q   <= digit_d;
      dig_sel_q <= dig_sel_d;
      ld_ack_q  <= ld_ack_d;
      frame_q   <= frame_d;
    end
  end

  assign digit   = digit_q;
  assign dig_sel = dig_sel_q;
  assign ld_ack  = ld_ack_q;
  assign frame   = frame_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with TICK_DIV=16 (16-cycle slots,
// 64-cycle frames). edgeNum counts rising edges since the last reset
// release; after edge n the counter is n%16 and the index (n/16)%4.
module tb_disp_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        en;
  logic        ld_req;
  logic [15:0] ld_data;
  logic        ld_ack;
  logic [2:0]  bright;
  logic        blank_lz;
  logic [3:0]  digit;
  logic [3:0]  dig_sel;
  logic        frame;

  int edgeNum;
  int checkCount;
  int errorCount;

  disp_scan_ctrl #(
    .TICK_DIV (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .ld_req   (ld_req),
    .ld_data  (ld_data),
    .ld_ack   (ld_ack),
    .bright   (bright),
    .blank_lz (blank_lz),
    .digit    (digit),
    .dig_sel  (dig_sel),
    .frame    (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the given edge number, then settle 2 time units so that
  // sampling and driving both happen well away from the rising edge.
  task automatic applyStimulus(input int target);
    while (edgeNum < target) begin
      @(posedge clk);
      edgeNum++;
    end
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      errorCount++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    edgeNum    = 0;
    checkCount = 0;
    errorCount = 0;
    rst      = 1'b0;
    en       = 1'b1;
    bright   = 3'd7;
    blank_lz = 1'b0;
    ld_req   = 1'b0;
    ld_data  = 16'h0000;

    // Reset state
    applyStimulus(3);
    checkOutput("rst_dig_sel", 16'(dig_sel), 16'h0);
    checkOutput("rst_digit",   16'(digit),   16'h0);
    checkOutput("rst_ld_ack",  16'(ld_ack),  16'h0);
    checkOutput("rst_frame",   16'(frame),   16'h0);

    // Scan order at full brightness
    rst = 1'b1;
    edgeNum = 0;
    applyStimulus(1);
    checkOutput("scan_d1_start", 16'(dig_sel), 16'h8);
    checkOutput("scan_digit0",   16'(digit),   16'h0);
    applyStimulus(15);
    checkOutput("scan_d1_end",   16'(dig_sel), 16'h8);
    applyStimulus(16);
    checkOutput("scan_d2",       16'(dig_sel), 16'h4);
    applyStimulus(32);
    checkOutput("scan_d3",       16'(dig_sel), 16'h2);
    applyStimulus(48);
    checkOutput("scan_d4",       16'(dig_sel), 16'h1);
    applyStimulus(63);
    checkOutput("frame_before",  16'(frame),   16'h0);
    checkOutput("scan_d4_end",   16'(dig_sel), 16'h1);
    applyStimulus(64);
    checkOutput("frame_pulse1",  16'(frame),   16'h1);
    checkOutput("scan_wrap",     16'(dig_sel), 16'h8);
    applyStimulus(65);
    checkOutput("frame_one_cyc", 16'(frame),   16'h0);
    applyStimulus(128);
    checkOutput("frame_pulse2",  16'(frame),   16'h1);

    // Load at frame cycle 10, applied at the next frame boundary
    applyStimulus(138);
    ld_req  = 1'b1;
    ld_data = 16'h1234;
    applyStimulus(150);
    checkOutput("ld_wait_ack",   16'(ld_ack), 16'h0);
    applyStimulus(191);
    checkOutput("ld_pre_ack",    16'(ld_ack), 16'h0);
    checkOutput("ld_pre_digit",  16'(digit),  16'h0);
    applyStimulus(192);
    checkOutput("ld_ack",        16'(ld_ack), 16'h1);
    checkOutput("ld_digit1",     16'(digit),  16'h1);
    checkOutput("ld_frame",      16'(frame),  16'h1);
    ld_req = 1'b0;
    applyStimulus(193);
    checkOutput("ld_ack_drop",   16'(ld_ack), 16'h0);
    applyStimulus(208);
    checkOutput("ld_digit2",     16'(digit),  16'h2);
    applyStimulus(224);
    checkOutput("ld_digit3",     16'(digit),  16'h3);
    applyStimulus(240);
    checkOutput("ld_digit4",     16'(digit),  16'h4);

    // Brightness: bright=1 gives 4 on-cycles per slot
    bright = 3'd1;
    applyStimulus(243);
    checkOutput("br1_on_last",   16'(dig_sel), 16'h1);
    applyStimulus(244);
    checkOutput("br1_off",       16'(dig_sel), 16'h0);
    applyStimulus(256);
    checkOutput("br1_next_slot", 16'(dig_sel), 16'h8);
    applyStimulus(260);
    checkOutput("br1_off2",      16'(dig_sel), 16'h0);
    applyStimulus(262);
    bright = 3'd3;
    applyStimulus(263);
    checkOutput("br3_not_yet",   16'(dig_sel), 16'h0);
    applyStimulus(272);
    checkOutput("br3_slot_on",   16'(dig_sel), 16'h4);
    applyStimulus(279);
    checkOutput("br3_on_last",   16'(dig_sel), 16'h4);
    applyStimulus(280);
    checkOutput("br3_off",       16'(dig_sel), 16'h0);

    // Leading-zero blanking with shadow 0x0070
    bright   = 3'd7;
    blank_lz = 1'b1;
    ld_req   = 1'b1;
    ld_data  = 16'h0070;
    applyStimulus(320);
    checkOutput("lz_ack",        16'(ld_ack),  16'h1);
    checkOutput("lz_d1_dark",    16'(dig_sel), 16'h0);
    ld_req = 1'b0;
    applyStimulus(336);
    checkOutput("lz_d2_dark",    16'(dig_sel), 16'h0);
    applyStimulus(352);
    checkOutput("lz_d3_sel",     16'(dig_sel), 16'h2);
    checkOutput("lz_d3_digit",   16'(digit),   16'h7);
    applyStimulus(368);
    checkOutput("lz_d4_sel",     16'(dig_sel), 16'h1);
    checkOutput("lz_d4_digit",   16'(digit),   16'h0);

    // Shadow 0x0000: only digit 4 lit
    ld_req  = 1'b1;
    ld_data = 16'h0000;
    applyStimulus(384);
    checkOutput("z_ack",         16'(ld_ack),  16'h1);
    ld_req = 1'b0;
    applyStimulus(390);
    checkOutput("z_d1_dark",     16'(dig_sel), 16'h0);
    applyStimulus(400);
    checkOutput("z_d2_dark",     16'(dig_sel), 16'h0);
    applyStimulus(416);
    checkOutput("z_d3_dark",     16'(dig_sel), 16'h0);
    applyStimulus(432);
    checkOutput("z_d4_lit",      16'(dig_sel), 16'h1);

    // Scan disabled: immediate load, display dark, resume at held index
    applyStimulus(440);
    en      = 1'b0;
    ld_req  = 1'b1;
    ld_data = 16'h9999;
    applyStimulus(441);
    checkOutput("en0_dark",      16'(dig_sel), 16'h0);
    checkOutput("en0_ack",       16'(ld_ack),  16'h1);
    checkOutput("en0_digit",     16'(digit),   16'h9);
    ld_req = 1'b0;
    applyStimulus(442);
    checkOutput("en0_ack_drop",  16'(ld_ack),  16'h0);
    checkOutput("en0_dark2",     16'(dig_sel), 16'h0);
    applyStimulus(445);
    en = 1'b1;
    applyStimulus(446);
    checkOutput("en1_resume",    16'(dig_sel), 16'h1);
    checkOutput("en1_digit",     16'(digit),   16'h9);
    applyStimulus(453);
    checkOutput("en1_frame",     16'(frame),   16'h1);
    checkOutput("en1_wrap",      16'(dig_sel), 16'h8);

    // Reset while a load is pending
    applyStimulus(460);
    ld_req   = 1'b1;
    ld_data  = 16'h5678;
    blank_lz = 1'b0;
    rst      = 1'b0;
    #1;
    checkOutput("mrst_dig_sel",  16'(dig_sel), 16'h0);
    checkOutput("mrst_digit",    16'(digit),   16'h0);
    checkOutput("mrst_ld_ack",   16'(ld_ack),  16'h0);
    checkOutput("mrst_frame",    16'(frame),   16'h0);
    edgeNum = 0;
    applyStimulus(3);
    checkOutput("mrst_hold_ack", 16'(ld_ack),  16'h0);
    checkOutput("mrst_hold_sel", 16'(dig_sel), 16'h0);
    ld_req = 1'b0;
    rst    = 1'b1;
    edgeNum = 0;
    applyStimulus(1);
    checkOutput("post_rst_sel",  16'(dig_sel), 16'h8);
    checkOutput("post_rst_dig",  16'(digit),   16'h0);
    checkOutput("post_rst_ack",  16'(ld_ack),  16'h0);
    applyStimulus(64);
    checkOutput("post_rst_frm",  16'(frame),   16'h1);
    checkOutput("post_rst_noack",16'(ld_ack),  16'h0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
